// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment capture block:
// segment patterns, FSM state encoding and default run length.
package seg7_pkg;

  localparam int unsigned STABLE_CNT_DEF = 4;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h27;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    HAVE_ONE = 2'd1,
    HAVE_TEN = 2'd2,
    LOCKED   = 2'd3
  } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Segment pattern (a..g in bits 0..6) to hex nibble decoder.
// Ports: SEG in; NIB decoded value; INVALID for unknown patterns.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] SEG,
  output logic [3:0] NIB,
  output logic       INVALID
);

  always_comb begin
    NIB     = 4'h0;
    INVALID = 1'b0;
    unique case (1'b1)
      (SEG == SEG_0): NIB = 4'h0;
      (SEG == SEG_1): NIB = 4'h1;
      (SEG == SEG_2): NIB = 4'h2;
      (SEG == SEG_3): NIB = 4'h3;
      (SEG == SEG_4): NIB = 4'h4;
      (SEG == SEG_5): NIB = 4'h5;
      (SEG == SEG_6): NIB = 4'h6;
      (SEG == SEG_7): NIB = 4'h7;
      (SEG == SEG_8): NIB = 4'h8;
      (SEG == SEG_9): NIB = 4'h9;
      (SEG == SEG_A): NIB = 4'hA;
      (SEG == SEG_B): NIB = 4'hB;
      (SEG == SEG_C): NIB = 4'hC;
      (SEG == SEG_D): NIB = 4'hD;
      (SEG == SEG_E): NIB = 4'hE;
      (SEG == SEG_F): NIB = 4'hF;
      default:        INVALID = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Debounced two-digit capture from a multiplexed 7-seg bus.
// Ports: CLK, RST_N, SEG/SEL/STB in; HBCD/LBCD/VALID/ERR out.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] SEG,
  input  logic       SEL,
  input  logic       STB,
  output logic [3:0] HBCD,
  output logic [3:0] LBCD,
  output logic       VALID,
  output logic       ERR
);

  localparam logic [3:0] K = 4'(STABLE_CNT);

  state_t     r_state, w_state_n;
  logic [6:0] r_last_l, r_last_h;
  logic [3:0] r_cnt_l, r_cnt_h;
  logic [3:0] r_sh_l, r_sh_h;
  logic [3:0] r_hbcd, r_lbcd;
  logic       r_valid, r_err;

  logic [6:0] w_last_n_l, w_last_n_h;
  logic [3:0] w_cnt_n_l, w_cnt_n_h;
  logic [3:0] w_sh_n_l, w_sh_n_h;
  logic [3:0] w_hbcd_n, w_lbcd_n;
  logic       w_valid_n, w_err_n;

  logic [6:0] w_last_cur;
  logic [3:0] w_cnt_cur, w_cnt_nxt;
  logic       w_same, w_acc;
  logic [3:0] w_nib;
  logic       w_inv;

  seg7_to_hex u_dec (
    .SEG     (SEG),
    .NIB     (w_nib),
    .INVALID (w_inv)
  );

  assign w_last_cur = SEL ? r_last_h : r_last_l;
  assign w_cnt_cur  = SEL ? r_cnt_h  : r_cnt_l;
  assign w_same     = (SEG == w_last_cur);

  assign w_cnt_nxt = !w_same        ? 4'd1 :
                     (w_cnt_cur == K) ? K    :
                     w_cnt_cur + 4'd1;

  // Accept only on the transition into K; a changed sample
  // restarts at 1, which is itself the transition when K is 1.
  assign w_acc = STB &&
                 (w_same ? (w_cnt_cur != K && w_cnt_nxt == K)
                         : (K == 4'd1));

  always_comb begin
    w_state_n  = r_state;
    w_last_n_l = r_last_l;
    w_last_n_h = r_last_h;
    w_cnt_n_l  = r_cnt_l;
    w_cnt_n_h  = r_cnt_h;
    w_sh_n_l   = r_sh_l;
    w_sh_n_h   = r_sh_h;
    w_hbcd_n   = r_hbcd;
    w_lbcd_n   = r_lbcd;
    w_valid_n  = 1'b0;
    w_err_n    = 1'b0;

    if (STB) begin
      if (SEL) begin
        w_last_n_h = SEG;
        w_cnt_n_h  = w_cnt_nxt;
      end else begin
        w_last_n_l = SEG;
        w_cnt_n_l  = w_cnt_nxt;
      end
    end

    if (w_acc && w_inv) begin
      w_err_n = 1'b1;
    end else if (w_acc) begin
      if (SEL) w_sh_n_h = w_nib;
      else     w_sh_n_l = w_nib;
      case (r_state)
        EMPTY:
          w_state_n = SEL ? HAVE_TEN : HAVE_ONE;
        HAVE_ONE:
          if (SEL) begin
            w_state_n = LOCKED;
            w_hbcd_n  = w_nib;
            w_lbcd_n  = r_sh_l;
            w_valid_n = 1'b1;
          end
        HAVE_TEN:
          if (!SEL) begin
            w_state_n = LOCKED;
            w_lbcd_n  = w_nib;
            w_hbcd_n  = r_sh_h;
            w_valid_n = 1'b1;
          end
        LOCKED:
          if (SEL) begin
            w_hbcd_n  = w_nib;
            w_valid_n = (w_nib != r_hbcd);
          end else begin
            w_lbcd_n  = w_nib;
            w_valid_n = (w_nib != r_lbcd);
          end
        default:
          w_state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= EMPTY;
      r_last_l <= '0;
      r_last_h <= '0;
      r_cnt_l  <= '0;
      r_cnt_h  <= '0;
      r_sh_l   <= '0;
      r_sh_h   <= '0;
      r_hbcd   <= '0;
      r_lbcd   <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_last_l <= w_last_n_l;
      r_last_h <= w_last_n_h;
      r_cnt_l  <= w_cnt_n_l;
      r_cnt_h  <= w_cnt_n_h;
      r_sh_l   <= w_sh_n_l;
      r_sh_h   <= w_sh_n_h;
      r_hbcd   <= w_hbcd_n;
      r_lbcd   <= w_lbcd_n;
      r_valid  <= w_valid_n;
      r_err    <= w_err_n;
    end
  end

  assign HBCD  = r_hbcd;
  assign LBCD  = r_lbcd;
  assign VALID = r_valid;
  assign ERR   = r_err;

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 SHALL provide parameter STABLE_CNT, default 4, the number of consecutive identical strobed samples needed to accept a digit; legal range 1..15.
REQ-002 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port SEG  input  7  segment pattern, bit0=a … bit6=g, 1=lit.
REQ-005 SHALL have port SEL  input  1  digit owner of SEG: 0=ones digit, 1=tens digit.
REQ-006 SHALL have port STB  input  1  sample strobe; SEG and SEL are sampled only on edges where STB=1.
REQ-007 SHALL have port HBCD  output  4  accepted tens-digit value.
REQ-008 SHALL have port LBCD  output  4  accepted ones-digit value.
REQ-009 SHALL have port VALID  output  1  one-cycle pulse marking a new or changed HBCD/LBCD pair.
REQ-010 SHALL have port ERR  output  1  one-cycle pulse marking a stable but undecodable pattern.

Function
REQ-011 SHALL decode patterns to nibbles: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 27→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F (hex); every other pattern is invalid.
REQ-012 SHALL keep, per digit, a last-sample register (7 bits) and a run counter (4 bits).
REQ-013 On a strobed sample equal to that digit's last sample, SHALL increment the run counter, saturating at STABLE_CNT.
REQ-014 On a strobed sample that differs from that digit's last sample, SHALL store the sample and set the run counter to 1.
REQ-015 SHALL "accept" a digit only on the edge where its run counter transitions to STABLE_CNT (for STABLE_CNT=1, on every changed sample); a pattern held longer SHALL NOT be re-accepted until it changes.
REQ-016 An accepted invalid pattern SHALL pulse ERR for one cycle and leave state, HBCD, LBCD and VALID unchanged.
REQ-017 SHALL implement FSM EMPTY, HAVE_ONE, HAVE_TEN, LOCKED. Each accepted valid digit loads that digit's shadow register.
REQ-018 FSM transitions on a valid ones accept: EMPTY→HAVE_ONE; HAVE_TEN→LOCKED.
REQ-019 FSM transitions on a valid tens accept: EMPTY→HAVE_TEN; HAVE_ONE→LOCKED.
REQ-020 A repeat accept of the already-held digit SHALL overwrite its shadow and leave the state unchanged.
REQ-021 On entry to LOCKED, SHALL copy both shadows to HBCD/LBCD and pulse VALID on the same edge as the completing accept (outputs visible the following cycle).
REQ-022 In LOCKED, each valid accept SHALL update the matching output; VALID pulses only if the new value differs from the current output.
REQ-023 Samples for one digit SHALL NOT affect the other digit's last-sample register or run counter.
REQ-024 STB=0 SHALL hold all state; VALID and ERR SHALL be 0 on every cycle not described above.

Reset
REQ-025 RST_N=0 SHALL immediately clear HBCD, LBCD, VALID, ERR, both shadows, both run counters and both last-sample registers to 0, and set the FSM to EMPTY.
REQ-026 Reset asserted mid-run SHALL discard partial runs; after release, a full STABLE_CNT-sample run is required before any accept.

Structure
REQ-027 Shared package seg7_pkg SHALL hold the 16 segment-pattern constants, the FSM state enum and the STABLE_CNT default.
REQ-028 The pattern-to-nibble mapping SHALL be one combinational sub-module, seg7_to_hex (inputs SEG; outputs nibble and invalid flag), instantiated once on the sampled SEG.

Verification
REQ-029 After reset, 4×(SEL=0, SEG=4F) then 4×(SEL=1, SEG=66) strobes -> VALID single pulse after the 8th strobe; HBCD=4, LBCD=3.
REQ-030 Ones digit held at 4F for 10 strobes while LOCKED with LBCD=3 -> no VALID and no ERR after the first accept.
REQ-031 LOCKED with LBCD=3, then 4×(SEL=0, SEG=7D) -> VALID pulse, LBCD=6, HBCD unchanged; then 4×(SEL=0, SEG=4F), 4×(SEL=0, SEG=7D) -> VALID pulses both times.
REQ-032 4×(SEL=0, SEG=00) after a change, or 4×(SEL=0, SEG=01) -> one ERR pulse, no VALID, state unchanged.
REQ-033 Interleaved ones/tens strobes, with a differing ones sample at the 3rd ones strobe -> ones run restarts, accept delayed to 4 identical ones samples, tens unaffected.
REQ-034 RST_N pulsed low after 3 of 4 matching strobes -> outputs 0 asynchronously; 1 more strobe gives no accept, 4 strobes give an accept.
